// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: accepts a binary value, converts it to BCD
// with a serial shift-add-3 engine, and scans the digits with registered outputs.
module seg7_scan_driver #(
  parameter int DIGITS      = 2,
  parameter int VAL_W       = 7,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              val_valid,
  input  logic [VAL_W-1:0]  val_data,
  output logic              val_ready,
  input  logic              blank,
  input  logic              lz_blank,
  input  logic              seg_pol,
  input  logic              com_pol,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] com_out,
  output logic              busy,
  output logic              ovf
);

  // state  | meaning
  // IDLE   | waiting for val_valid, val_ready high
  // CONV   | one shift-add-3 step per cycle, VAL_W cycles
  // COMMIT | load display nibbles and ovf, back to IDLE

  localparam int NB    = 5;  // enough BCD nibbles for a 14-bit value
  localparam int BCD_W = 4 * NB;
  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [VAL_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d, ovf_chk;
  logic                loaded_q, loaded_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [IDX_W-1:0]    idx_q, idx_d, sel_idx;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   com_q, com_d;
  logic [3:0]          sel_nib;
  logic                sup;
  logic [6:0]          pat;

  function automatic logic [6:0] seg7_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg7_dec = 7'h3F;
      4'd1:    seg7_dec = 7'h06;
      4'd2:    seg7_dec = 7'h5B;
      4'd3:    seg7_dec = 7'h4F;
      4'd4:    seg7_dec = 7'h66;
      4'd5:    seg7_dec = 7'h6D;
      4'd6:    seg7_dec = 7'h7D;
      4'd7:    seg7_dec = 7'h07;
      4'd8:    seg7_dec = 7'h7F;
      4'd9:    seg7_dec = 7'h6F;
      default: seg7_dec = 7'h00;
    endcase
  endfunction

  always_comb begin : fsm_next
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    loaded_d = loaded_q;
    bcd_adj  = bcd_q;
    ovf_chk  = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      if (k >= DIGITS) ovf_chk = ovf_chk | (|bcd_q[4*k +: 4]);
    end
    case (state_q)
      S_IDLE: begin
        if (val_valid) begin
          bin_d   = val_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(VAL_W - 1);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        if (cnt_q == '0) state_d = S_COMMIT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_COMMIT: begin
        disp_d   = bcd_q[4*DIGITS-1:0];
        ovf_d    = ovf_chk;
        loaded_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : scan_next
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Reset is folded in here so the output registers show the reset pattern
  // on the very edge that resets the scan.
  always_comb begin : out_next
    sel_idx = rst ? '0 : idx_q;
    sel_nib = '0;
    sup     = 1'b0;
    pat     = '0;
    com_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_nib = disp_q[4*i +: 4];
        sup     = (i > 0);
        for (int j = 0; j < DIGITS; j++) begin
          if (j >= i && disp_q[4*j +: 4] != 4'd0) sup = 1'b0;
        end
      end
      com_d[i] = (IDX_W'(i) == sel_idx && !blank) ? com_pol : ~com_pol;
    end
    if (rst || !loaded_q || blank) pat = '0;
    else if (ovf_q)                pat = 7'h40;
    else if (lz_blank && sup)      pat = '0;
    else                           pat = seg7_dec(sel_nib);
    seg_d = seg_pol ? {1'b0, pat} : ~{1'b0, pat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      loaded_q <= 1'b0;
      ref_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      loaded_q <= loaded_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
    end
    seg_q <= seg_d;
    com_q <= com_d;
  end

  assign val_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ovf       = ovf_q;
  assign seg_out   = seg_q;
  assign com_out   = com_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle model built from decimal arithmetic,
// directed literal checks, then randomized traffic.
module tb_seg7_scan_driver;
  localparam int DIG = 2;
  localparam int VW  = 7;
  localparam int RD  = 4;

  logic           clk = 1'b0;
  logic           rst, val_valid, blank, lz_blank, seg_pol, com_pol;
  logic [VW-1:0]  val_data;
  logic           val_ready, busy, ovf;
  logic [7:0]     seg_out;
  logic [DIG-1:0] com_out;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(.DIGITS(DIG), .VAL_W(VW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .val_valid(val_valid), .val_data(val_data),
    .val_ready(val_ready), .blank(blank), .lz_blank(lz_blank),
    .seg_pol(seg_pol), .com_pol(com_pol), .seg_out(seg_out),
    .com_out(com_out), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int         P10[5] = '{1, 10, 100, 1000, 10000};
  logic [6:0] PAT[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_pat(int i, int v, bit ld, bit ov, bit lz);
    if (!ld) return 7'h00;
    if (ov) return 7'h40;
    if (lz && i > 0 && v < P10[i]) return 7'h00;
    return PAT[(v / P10[i]) % 10];
  endfunction

  // model: value-level state, scan position derived from cycles since reset
  int             m_cyc, m_busy, m_pend, m_val;
  bit             m_loaded, m_ovf, m_on = 0;
  logic [7:0]     e_seg;
  logic [DIG-1:0] e_com;
  bit             e_ready, e_busy, e_ovf;

  always @(posedge clk) begin
    int idx;
    logic [6:0] p;
    if (rst) begin
      idx = 0;
      p = 7'h00;
    end else begin
      idx = (m_cyc / RD) % DIG;
      p = model_pat(idx, m_val, m_loaded, m_ovf, lz_blank);
    end
    if (blank) p = 7'h00;
    e_seg = seg_pol ? {1'b0, p} : ~{1'b0, p};
    for (int i = 0; i < DIG; i++) e_com[i] = (i == idx && !blank) ? com_pol : ~com_pol;
    if (rst) begin
      m_cyc = 0; m_busy = 0; m_loaded = 0; m_ovf = 0; m_val = 0; m_on = 1;
    end else begin
      m_cyc++;
      if (m_busy == 0) begin
        if (val_valid) begin
          m_pend = int'(val_data);
          m_busy = VW + 1;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_val = m_pend;
          m_ovf = (m_pend >= P10[DIG]);
          m_loaded = 1;
        end
      end
    end
    e_ready = (m_busy == 0);
    e_busy  = !e_ready;
    e_ovf   = m_ovf;
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_ready", val_ready, e_ready);
      chk("m_busy",  busy,      e_busy);
      chk("m_ovf",   ovf,       e_ovf);
      chk("m_seg",   seg_out,   e_seg);
      chk("m_com",   com_out,   e_com);
    end
  end

  task automatic send(input int v, output int bcyc);
    int t = 0;
    while (!val_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin total++; bad++; $display("FAIL send_ready timeout got=0 want=1"); end
    val_valid = 1'b1;
    val_data  = VW'(v);
    @(negedge clk);
    val_valid = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 50) begin @(negedge clk); bcyc++; end
  endtask

  task automatic wait_com(input logic [DIG-1:0] c, input logic [7:0] s, input string nm);
    int t = 0;
    @(negedge clk);
    while (com_out !== c && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      total++; bad++;
      $display("FAIL %s_com timeout got=%b want=%b", nm, com_out, c);
    end else chk(nm, seg_out, s);
  endtask

  initial begin
    int b;
    rst = 1'b1; val_valid = 1'b0; val_data = '0; blank = 1'b0;
    lz_blank = 1'b0; seg_pol = 1'b1; com_pol = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", val_ready, 1);
    chk("rst_busy",  busy,      0);
    chk("rst_ovf",   ovf,       0);
    chk("rst_seg",   seg_out,   8'h00);
    for (int k = 0; k < 9; k++) begin
      chk("rst_scan", com_out, (k < 5) ? 2'b01 : 2'b10);
      @(negedge clk);
    end

    send(42, b);
    chk("busy_len", b, 8);
    wait_com(2'b01, 8'h5B, "d0_42");
    wait_com(2'b10, 8'h66, "d1_42");

    lz_blank = 1'b1;
    send(7, b);
    wait_com(2'b01, 8'h07, "d0_7");
    wait_com(2'b10, 8'h00, "d1_7_lz");
    lz_blank = 1'b0;
    wait_com(2'b10, 8'h3F, "d1_7_nolz");
    lz_blank = 1'b1;
    send(0, b);
    wait_com(2'b01, 8'h3F, "d0_0");
    wait_com(2'b10, 8'h00, "d1_0_lz");

    send(120, b);
    chk("ovf_120", ovf, 1);
    wait_com(2'b01, 8'h40, "d0_120");
    wait_com(2'b10, 8'h40, "d1_120");
    send(99, b);
    chk("ovf_99", ovf, 0);
    wait_com(2'b01, 8'h6F, "d0_99");
    wait_com(2'b10, 8'h6F, "d1_99");

    lz_blank = 1'b0;
    send(42, b);
    seg_pol = 1'b0; com_pol = 1'b0;
    wait_com(2'b10, 8'hA4, "d0_inv");
    wait_com(2'b01, 8'h99, "d1_inv");
    blank = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("blank_com", com_out, 2'b11);
    chk("blank_seg", seg_out, 8'hFF);
    blank = 1'b0; seg_pol = 1'b1; com_pol = 1'b1;

    // reset in the middle of a conversion, with a value offered while busy
    @(negedge clk);
    val_valid = 1'b1; val_data = VW'(42);
    @(negedge clk);
    val_data = VW'(13);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; val_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", val_ready, 1);
    chk("abort_ovf",   ovf,       0);
    chk("abort_seg",   seg_out,   8'h00);
    repeat (12) @(negedge clk);
    chk("abort_busy", busy, 0);
    wait_com(2'b01, 8'h00, "abort_d0");
    wait_com(2'b10, 8'h00, "abort_d1");

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      val_valid = ($urandom % 3 == 0);
      case ($urandom % 4)
        0:       val_data = VW'($urandom % 10);
        1:       val_data = VW'(90 + $urandom % 38);
        default: val_data = VW'($urandom % 128);
      endcase
      if ($urandom % 16 == 0) lz_blank = $urandom % 2;
      if ($urandom % 32 == 0) blank = ($urandom % 4 == 0);
      if ($urandom % 64 == 0) seg_pol = $urandom % 2;
      if ($urandom % 64 == 0) com_pol = $urandom % 2;
      rst = ($urandom % 300 == 0);
    end
    rst = 1'b0; val_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of multiplexed 7-segment digits (1..4).
REQ-002 SHALL have parameter VAL_W, default 7, binary input value width (1..14).
REQ-003 SHALL have parameter REFRESH_DIV, default 1000, clock cycles each digit stays selected (>=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port val_valid  input  1  new value offered.
REQ-007 SHALL have port val_data  input  VAL_W  unsigned binary value to display.
REQ-008 SHALL have port val_ready  output  1  block can accept a value.
REQ-009 SHALL have port blank  input  1  1 = whole display dark.
REQ-010 SHALL have port lz_blank  input  1  1 = suppress leading zeros.
REQ-011 SHALL have port seg_pol  input  1  level at which a segment is lit.
REQ-012 SHALL have port com_pol  input  1  level at which a digit common is active.
REQ-013 SHALL have port seg_out  output  8  segments {dp,g,f,e,d,c,b,a}; dp never lit.
REQ-014 SHALL have port com_out  output  DIGITS  digit commons; bit 0 = ones digit.
REQ-015 SHALL have port busy  output  1  conversion in progress.
REQ-016 SHALL have port ovf  output  1  last committed value exceeded 10^DIGITS-1.

Function
REQ-017 FSM states SHALL be IDLE, CONV, COMMIT; val_ready = (state==IDLE); busy = (state!=IDLE).
REQ-018 Transfer SHALL occur on a cycle with val_valid && val_ready; val_data captured, IDLE->CONV.
REQ-019 CONV SHALL perform shift-add-3 binary-to-BCD, one bit per cycle, exactly VAL_W cycles, then ->COMMIT.
REQ-020 COMMIT SHALL load display registers and ovf in one cycle, then ->IDLE; val_ready high the following cycle.
REQ-021 Latency from transfer edge to updated display registers SHALL be VAL_W+1 cycles.
REQ-022 val_valid while busy SHALL be ignored; displayed digits hold previous value during CONV.
REQ-023 If captured value >= 10^DIGITS, COMMIT SHALL set ovf=1 and every digit to dash pattern 0x40; else ovf=0.
REQ-024 Patterns SHALL be 0:0x3F 1:0x06 2:0x5B 3:0x4F 4:0x66 5:0x6D 6:0x7D 7:0x07 8:0x7F 9:0x6F, empty:0x00.
REQ-025 With lz_blank=1, digit i>0 SHALL be empty when it and all higher digits are zero; digit 0 always shown; no suppression when ovf=1.
REQ-026 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index advances, DIGITS-1 wraps to 0.
REQ-027 com_out[i] SHALL equal com_pol when i==index and blank=0, otherwise ~com_pol.
REQ-028 seg_out SHALL equal pattern of selected digit when seg_pol=1, its bitwise inverse when seg_pol=0; pattern forced empty when blank=1.
REQ-029 seg_out and com_out SHALL change only with the registered index/digits, never glitch between digits within a cycle (registered outputs, 1-cycle delay from index allowed).
REQ-030 Polarity and blank inputs SHALL take effect within one cycle without disturbing scan or FSM.

Reset
REQ-031 rst SHALL force state IDLE, refresh counter 0, index 0, ovf 0, all digits empty, discarding any conversion in progress.
REQ-032 During and one cycle after rst: val_ready=1 (after release), busy=0, seg_out = all unlit per seg_pol, com_out per REQ-027 with index 0.
REQ-033 First val_valid accepted SHALL be the one sampled in the first cycle with rst=0.

Verification (DIGITS=2, VAL_W=7, REFRESH_DIV=4)
REQ-034 Reset, seg_pol=1, com_pol=1 -> val_ready=1, busy=0, ovf=0, seg_out=0x00, com_out cycles 01,10 every 4 cycles.
REQ-035 Send 42 -> busy high 8 cycles, then seg_out=0x5B while com_out=01, 0x66 while com_out=10.
REQ-036 Send 7, lz_blank=1 -> 0x07 on digit 0, 0x00 on digit 1; lz_blank=0 -> digit 1 shows 0x3F; send 0 with lz_blank=1 -> 0x3F / 0x00.
REQ-037 Send 120 -> ovf=1, both digits 0x40; then send 99 -> ovf=0, 0x6F/0x6F.
REQ-038 42 displayed, seg_pol=0, com_pol=0 -> seg_out=0xA4 while com_out=10, 0x99 while com_out=01; blank=1 -> com_out=11, seg_out=0xFF.
REQ-039 Send 42, assert val_valid with 13 during CONV (ignored), assert rst on 4th CONV cycle -> after release display empty, ovf=0, val_ready=1.
